// File: rtl/fpu_addsub_rr_scheduler.sv
// Round-robin front end that shares one pipelined FP32 add/sub unit among NUM_REQ requesters.
// Latency: grant is combinational, issue is registered (+1), result is returned FPU_LAT+2 cycles after the handshake.
// Backpressure: i_hold or the absence of a grant stalls requesters; responses have no backpressure and always drain.
module fpu_addsub_rr_scheduler #(
    parameter int SIZE_DATA = 32,
    parameter int NUM_REQ   = 4,
    parameter int FPU_LAT   = 3
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_hold,
    input  logic [NUM_REQ-1:0]           i_req_valid,
    input  logic [NUM_REQ-1:0]           i_req_op,
    input  logic [NUM_REQ*SIZE_DATA-1:0] i_req_a,
    input  logic [NUM_REQ*SIZE_DATA-1:0] i_req_b,
    output logic [NUM_REQ-1:0]           o_req_ready,
    output logic                         o_fpu_valid,
    output logic                         o_fpu_op,
    output logic [SIZE_DATA-1:0]         o_fpu_a,
    output logic [SIZE_DATA-1:0]         o_fpu_b,
    input  logic [SIZE_DATA-1:0]         i_fpu_result,
    output logic [NUM_REQ-1:0]           o_rsp_valid,
    output logic [SIZE_DATA-1:0]         o_rsp_data,
    output logic [$clog2(FPU_LAT+2):0]   o_inflight,
    output logic                         o_busy
);

    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW  = $clog2(FPU_LAT + 2) + 1;

    // arbitration
    logic [IDW-1:0]       ptr_q, ptr_d;
    logic [IDW-1:0]       gnt_id, cand_id;
    logic                 found, hs;
    logic [NUM_REQ-1:0]   gnt;

    // issue registers
    logic                 fpu_vld_q, fpu_vld_d;
    logic                 fpu_op_q, fpu_op_d;
    logic [SIZE_DATA-1:0] fpu_a_q, fpu_a_d;
    logic [SIZE_DATA-1:0] fpu_b_q, fpu_b_d;
    logic [IDW-1:0]       iss_id_q, iss_id_d;

    // tag pipe tracking which requester owns each op inside the unit
    logic [FPU_LAT-1:0]   tag_vld_q, tag_vld_d;
    logic [IDW-1:0]       tag_id_q [FPU_LAT];
    logic [IDW-1:0]       tag_id_d [FPU_LAT];

    // response and occupancy
    logic [NUM_REQ-1:0]   rsp_vld_q, rsp_vld_d;
    logic [SIZE_DATA-1:0] rsp_dat_q, rsp_dat_d;
    logic [CW-1:0]        infl_q, infl_d;

    // Round-robin search starting at ptr; hold and reset suppress any grant.
    always_comb begin
        found   = 1'b0;
        gnt_id  = '0;
        cand_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_id = IDW'((int'(ptr_q) + i) % NUM_REQ);
            if (!found && i_req_valid[cand_id]) begin
                found  = 1'b1;
                gnt_id = cand_id;
            end
        end
        hs  = found && !i_hold && i_rst_n;
        gnt = '0;
        if (hs) begin
            gnt[gnt_id] = 1'b1;
        end
    end

    // Next-state for pointer, issue stage, tag pipe, response and in-flight count.
    always_comb begin
        ptr_d     = ptr_q;
        fpu_vld_d = hs;
        fpu_op_d  = fpu_op_q;
        fpu_a_d   = fpu_a_q;
        fpu_b_d   = fpu_b_q;
        iss_id_d  = iss_id_q;
        if (hs) begin
            ptr_d    = (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + IDW'(1);
            fpu_op_d = i_req_op[gnt_id];
            fpu_a_d  = i_req_a[int'(gnt_id)*SIZE_DATA +: SIZE_DATA];
            fpu_b_d  = i_req_b[int'(gnt_id)*SIZE_DATA +: SIZE_DATA];
            iss_id_d = gnt_id;
        end

        // Stage 0 follows the issue cycle, so the last stage lines up with the unit result.
        tag_vld_d    = '0;
        tag_vld_d[0] = fpu_vld_q;
        tag_id_d[0]  = iss_id_q;
        for (int i = 1; i < FPU_LAT; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_id_d[i]  = tag_id_q[i-1];
        end

        rsp_vld_d = '0;
        rsp_dat_d = rsp_dat_q;
        if (tag_vld_q[FPU_LAT-1]) begin
            rsp_vld_d[tag_id_q[FPU_LAT-1]] = 1'b1;
            rsp_dat_d                      = i_fpu_result;
        end

        // An op counts from its issue cycle through its response cycle inclusive.
        infl_d = infl_q + CW'(hs) - CW'(|rsp_vld_q);
    end

    // State registers; reset drops everything in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_q     <= '0;
            fpu_vld_q <= 1'b0;
            fpu_op_q  <= 1'b0;
            fpu_a_q   <= '0;
            fpu_b_q   <= '0;
            iss_id_q  <= '0;
            tag_vld_q <= '0;
            for (int i = 0; i < FPU_LAT; i++) begin
                tag_id_q[i] <= '0;
            end
            rsp_vld_q <= '0;
            rsp_dat_q <= '0;
            infl_q    <= '0;
        end else begin
            ptr_q     <= ptr_d;
            fpu_vld_q <= fpu_vld_d;
            fpu_op_q  <= fpu_op_d;
            fpu_a_q   <= fpu_a_d;
            fpu_b_q   <= fpu_b_d;
            iss_id_q  <= iss_id_d;
            tag_vld_q <= tag_vld_d;
            tag_id_q  <= tag_id_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_dat_q <= rsp_dat_d;
            infl_q    <= infl_d;
        end
    end

    assign o_req_ready = gnt;
    assign o_fpu_valid = fpu_vld_q;
    assign o_fpu_op    = fpu_op_q;
    assign o_fpu_a     = fpu_a_q;
    assign o_fpu_b     = fpu_b_q;
    assign o_rsp_valid = rsp_vld_q;
    assign o_rsp_data  = rsp_dat_q;
    assign o_inflight  = infl_q;
    assign o_busy      = (infl_q != '0);

endmodule

// File: tb/tb_fpu_addsub_rr_scheduler.sv
// Directed bench for the add/sub round-robin scheduler with a fixed-latency stand-in unit.
// Latency: the stand-in unit answers FPU_LAT cycles after o_fpu_valid.
// Backpressure: requesters are driven directly each cycle; responses are always accepted.
module tb_fpu_addsub_rr_scheduler;

    localparam int SD  = 32;
    localparam int NR  = 4;
    localparam int LAT = 3;
    localparam int CW  = $clog2(LAT + 2) + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             hold = 1'b0;
    logic [NR-1:0]    req_valid = '0;
    logic [NR-1:0]    req_op = '0;
    logic [NR*SD-1:0] req_a = '0;
    logic [NR*SD-1:0] req_b = '0;
    logic [NR-1:0]    o_req_ready;
    logic             o_fpu_valid;
    logic             o_fpu_op;
    logic [SD-1:0]    o_fpu_a;
    logic [SD-1:0]    o_fpu_b;
    logic [SD-1:0]    fpu_result;
    logic [NR-1:0]    o_rsp_valid;
    logic [SD-1:0]    o_rsp_data;
    logic [CW-1:0]    o_inflight;
    logic             o_busy;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int infl_max = 0;

    logic [SD-1:0] ra [NR];
    logic [SD-1:0] rb [NR];
    logic          rop [NR];

    logic          exp_iss [int];
    logic [SD-1:0] exp_a [int];
    logic [SD-1:0] exp_b [int];
    logic          exp_op [int];
    logic [NR-1:0] exp_rsp [int];
    logic [SD-1:0] exp_dat [int];

    logic [SD-1:0] fpu_pipe [LAT];

    fpu_addsub_rr_scheduler #(.SIZE_DATA(SD), .NUM_REQ(NR), .FPU_LAT(LAT)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_hold       (hold),
        .i_req_valid  (req_valid),
        .i_req_op     (req_op),
        .i_req_a      (req_a),
        .i_req_b      (req_b),
        .o_req_ready  (o_req_ready),
        .o_fpu_valid  (o_fpu_valid),
        .o_fpu_op     (o_fpu_op),
        .o_fpu_a      (o_fpu_a),
        .o_fpu_b      (o_fpu_b),
        .i_fpu_result (fpu_result),
        .o_rsp_valid  (o_rsp_valid),
        .o_rsp_data   (o_rsp_data),
        .o_inflight   (o_inflight),
        .o_busy       (o_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in unit: known FP vectors return their IEEE result, anything else an integer stand-in.
    function automatic logic [SD-1:0] model(input logic [SD-1:0] a, input logic [SD-1:0] b, input logic op);
        if (a == 32'h3F80_0000 && b == 32'h4000_0000 && !op) return 32'h4040_0000;
        if (a == 32'h4040_0000 && b == 32'h3F80_0000 && op)  return 32'h4000_0000;
        return op ? (a - b) : (a + b);
    endfunction

    always @(posedge clk) begin
        fpu_pipe[0] <= o_fpu_valid ? model(o_fpu_a, o_fpu_b, o_fpu_op) : 32'hDEAD_BEEF;
        for (int i = 1; i < LAT; i++) fpu_pipe[i] <= fpu_pipe[i-1];
    end
    assign fpu_result = fpu_pipe[LAT-1];

    task automatic chk(input string tag, input logic [SD-1:0] act, input logic [SD-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, act, exp);
        end
    endtask

    // One cycle of requester stimulus; a granted op schedules its issue and response expectations.
    task automatic drv(input logic [NR-1:0] vld, input logic hld, input logic [NR-1:0] exp_rdy, input string tag);
        int k;
        @(negedge clk);
        req_valid = vld;
        hold      = hld;
        for (int j = 0; j < NR; j++) begin
            req_a[j*SD +: SD] = ra[j];
            req_b[j*SD +: SD] = rb[j];
            req_op[j]         = rop[j];
        end
        #1;
        chk(tag, 32'(o_req_ready), 32'(exp_rdy));
        if (exp_rdy != '0) begin
            k = 0;
            for (int j = 0; j < NR; j++) if (exp_rdy[j]) k = j;
            exp_iss[cyc+1] = 1'b1;
            exp_a[cyc+1]   = ra[k];
            exp_b[cyc+1]   = rb[k];
            exp_op[cyc+1]  = rop[k];
            exp_rsp[cyc+5] = exp_rdy;
            exp_dat[cyc+5] = model(ra[k], rb[k], rop[k]);
            ra[k] = ra[k] + 32'h0001_0101;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drv('0, 1'b0, '0, "idle_rdy");
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        req_valid = '0;
        hold      = 1'b0;
        rst_n     = 1'b0;
        exp_iss.delete(); exp_a.delete(); exp_b.delete(); exp_op.delete();
        exp_rsp.delete(); exp_dat.delete();
        #1;
        chk({tag, "_ready"}, 32'(o_req_ready), 0);
        chk({tag, "_fvld"},  32'(o_fpu_valid), 0);
        chk({tag, "_fop"},   32'(o_fpu_op), 0);
        chk({tag, "_fa"},    o_fpu_a, 0);
        chk({tag, "_fb"},    o_fpu_b, 0);
        chk({tag, "_rvld"},  32'(o_rsp_valid), 0);
        chk({tag, "_rdat"},  o_rsp_data, 0);
        chk({tag, "_infl"},  32'(o_inflight), 0);
        chk({tag, "_busy"},  32'(o_busy), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Per-cycle monitor: issue and response strobes against the scheduled expectations.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (exp_iss.exists(cyc)) begin
                chk("iss_vld", 32'(o_fpu_valid), 1);
                chk("iss_a", o_fpu_a, exp_a[cyc]);
                chk("iss_b", o_fpu_b, exp_b[cyc]);
                chk("iss_op", 32'(o_fpu_op), 32'(exp_op[cyc]));
            end else begin
                chk("iss_idle", 32'(o_fpu_valid), 0);
            end
            if (exp_rsp.exists(cyc)) begin
                chk("rsp_vld", 32'(o_rsp_valid), 32'(exp_rsp[cyc]));
                chk("rsp_dat", o_rsp_data, exp_dat[cyc]);
            end else begin
                chk("rsp_idle", 32'(o_rsp_valid), 0);
            end
            if (int'(o_inflight) > infl_max) infl_max = int'(o_inflight);
        end
    end

    initial begin
        for (int k = 0; k < NR; k++) begin
            ra[k]  = 32'h1000_0000 * (k + 1);
            rb[k]  = 32'h0000_0100 * (k + 1);
            rop[k] = 1'b0;
        end
        #2;
        do_reset("rst0");

        // single add from requester 0: 1.0 + 2.0
        ra[0] = 32'h3F80_0000; rb[0] = 32'h4000_0000; rop[0] = 1'b0;
        drv(4'b0001, 1'b0, 4'b0001, "t2_rdy");
        chk("t2_infl_t", 32'(o_inflight), 0);
        drv('0, 1'b0, '0, "t2_idle");
        chk("t2_infl_t1", 32'(o_inflight), 1);
        idle(3);
        drv('0, 1'b0, '0, "t2_idle5");
        chk("t2_rsp", 32'(o_rsp_valid), 32'h1);
        chk("t2_dat", o_rsp_data, 32'h4040_0000);
        chk("t2_infl_t5", 32'(o_inflight), 1);
        drv('0, 1'b0, '0, "t2_idle6");
        chk("t2_infl_t6", 32'(o_inflight), 0);
        chk("t2_busy_t6", 32'(o_busy), 0);
        chk("t2_a_hold", o_fpu_a, 32'h3F80_0000);
        chk("t2_dat_hold", o_rsp_data, 32'h4040_0000);

        // subtract from requester 1: 3.0 - 1.0
        ra[1] = 32'h4040_0000; rb[1] = 32'h3F80_0000; rop[1] = 1'b1;
        drv(4'b0010, 1'b0, 4'b0010, "t6_rdy");
        drv('0, 1'b0, '0, "t6_idle");
        chk("t6_op", 32'(o_fpu_op), 1);
        idle(3);
        drv('0, 1'b0, '0, "t6_idle5");
        chk("t6_rsp", 32'(o_rsp_valid), 32'h2);
        chk("t6_dat", o_rsp_data, 32'h4000_0000);
        idle(2);
        rop[1] = 1'b0;

        // pointer: grant 2, then req0+req3 -> 3 first, then 0
        drv(4'b0100, 1'b0, 4'b0100, "t4_g2");
        drv(4'b1001, 1'b0, 4'b1000, "t4_g3");
        drv(4'b0001, 1'b0, 4'b0001, "t4_g0");
        idle(6);

        // hold with two ops in flight (ptr now 1)
        drv(4'b0110, 1'b0, 4'b0010, "t5_g1");
        drv(4'b0100, 1'b0, 4'b0100, "t5_g2");
        drv(4'b1001, 1'b1, '0, "t5_hold0");
        drv(4'b1001, 1'b1, '0, "t5_hold1");
        drv(4'b1001, 1'b1, '0, "t5_hold2");
        chk("t5_busy_hold", 32'(o_busy), 1);
        idle(3);
        chk("t5_busy_drain", 32'(o_busy), 0);
        chk("t5_infl_drain", 32'(o_inflight), 0);
        drv(4'b1001, 1'b0, 4'b1000, "t5_resume3");
        drv(4'b0001, 1'b0, 4'b0001, "t5_then0");
        idle(6);

        // reset mid-stream with two ops in flight
        drv(4'b0010, 1'b0, 4'b0010, "t1_g1");
        drv(4'b0100, 1'b0, 4'b0100, "t1_g2");
        do_reset("rst1");
        idle(8);
        chk("t1_infl", 32'(o_inflight), 0);
        chk("t1_busy", 32'(o_busy), 0);

        // fairness: all four valid for 8 cycles from ptr 0
        infl_max = 0;
        for (int i = 0; i < 8; i++) begin
            logic [NR-1:0] exp_g;
            exp_g = '0;
            exp_g[i % NR] = 1'b1;
            drv(4'b1111, 1'b0, exp_g, "t3_rr");
        end
        idle(7);
        chk("t3_peak", 32'(infl_max), 5);
        chk("t3_busy_end", 32'(o_busy), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
